lcd_timing_gen: RTL and testbench
=================================

# lcd_timing_gen

Parametrised LVDS-panel timing and test-pattern generator running in the pixel clock domain. Produces registered HSYNC/VSYNC/DE, pixel coordinates and RGB for any panel geometry and colour depth, with selectable test patterns or external pixel passthrough. Its outputs feed the 7:1 serialiser data word; it supersedes the hard-coded 1366×768 cycle/video generator.

## Interface
- H_ACTIVE, 1366, visible pixels per line
- H_FP / H_SYNC / H_BP, 30 / 114 / 30, horizontal front porch / sync width / back porch (cycles)
- V_ACTIVE, 768, visible lines per frame
- V_FP / V_SYNC / V_BP, 3 / 5 / 4, vertical front porch / sync width / back porch (lines)
- SYNC_POL, 1, active level of hsync/vsync (1 = active-high)
- BPC, 6, bits per colour channel (4..10)
- CW, 12, coordinate counter width; H_TOTAL and V_TOTAL must be < 2^CW
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  run request
- mode  in  2  pattern select: 0 colour bars, 1 checkerboard, 2 grey ramp, 3 external
- px_in  in  3*BPC  external pixel {R,G,B}
- px_req  out  1  pixel (pos_x,pos_y) is active this cycle; px_in must be valid this cycle
- hsync, vsync, de  out  1  panel timing
- rgb_out  out  3*BPC  pixel {R,G,B}, zero when de=0
- pos_x, pos_y  out  CW  coordinates of the pixel currently presented
- frame_start  out  1  one-cycle pulse with pixel (0,0)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Counters h (0..H_TOTAL-1), v (0..V_TOTAL-1); h wraps to 0 and increments v; v wraps to 0 after H_TOTAL-1 of line V_TOTAL-1.
- FSM: IDLE → RUN when en=1 at an edge in IDLE. RUN → IDLE only at the last cycle of a frame (h=H_TOTAL-1, v=V_TOTAL-1) with en=0; en=0 mid-frame does not truncate the frame. In IDLE, counters hold at (0,0); px_req=0.
- Active: RUN and h<H_ACTIVE and v<V_ACTIVE (= px_req).
- hsync active for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). vsync active for whole lines v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), switching on h=0 boundaries. Inactive level = ~SYNC_POL. Syncs run during vertical blanking lines as normal.
- mode sampled into a frame register at each transition to (0,0) (including IDLE→RUN); changes mid-frame take effect next frame.
- Patterns (M = 2^BPC-1): mode 0 eight bars, width BW = H_ACTIVE/8, bar k = h/BW clamped to 7; order white, yellow, cyan, green, magenta, red, blue, black. Mode 1: white if h[5]^v[5] else black. Mode 2: R=G=B=h[BPC-1:0]. Mode 3: px_in.
- Bar boundaries from compare against constant multiples of BW; no runtime divider.

## Timing
- Single output register stage: hsync, vsync, de, rgb_out, pos_x, pos_y, frame_start reflect the counter state of the previous cycle; all mutually aligned. px_req is the same-cycle counter-stage flag, so px_in sampled with px_req=1 appears on rgb_out with de=1 one cycle later.
- First de after enable: en sampled high at edge N (IDLE→RUN); px_req=1 after edge N; de=1, frame_start=1 after edge N+1.
- Reset (any time, asynchronous): FSM IDLE, counters 0, mode register 0, hsync=vsync=~SYNC_POL, de=0, rgb_out=0, pos 0, frame_start=0, px_req=0. Release resumes from IDLE.
- Blanking: rgb_out forced to 0 whenever de=0, in every mode.

## Configuration
- LCD_TG_PATTERN_EN defined: pattern logic and mode register built; behaviour as above.
- Undefined: mode ignored, no pattern logic; rgb_out is always registered px_in (gated to 0 when inactive); all timing unchanged.

## Test plan
Bench parameters: H_ACTIVE 8, H_FP 2, H_SYNC 3, H_BP 1 (H_TOTAL 14); V_ACTIVE 4, V_FP 1, V_SYNC 2, V_BP 1 (V_TOTAL 8); BPC 6; SYNC_POL 1.
- Reset/start: rst_n=0 → hsync=vsync=0, de=0, rgb_out=0; release, en=1 at edge N → frame_start and de high after edge N+1, pos=(0,0).
- Line: de high 8 cycles, low 6; hsync high exactly 3 cycles, starting 10 cycles after de rise; period 14.
- Frame: de in lines 0..3 only; vsync high 28 cycles starting with pos=(0,5); frame_start every 112 cycles.
- Patterns: mode 0 → pixel 0 rgb_out=0x3FFFF, pixel 7 =0; mode 2 → pixel 5 R=G=B=5; mode 3 with px_in=0x12345 during px_req → rgb_out=0x12345 next cycle; mode written mid-frame changes output only from next frame_start.
- Stop: en=0 at pos (3,1) → frame completes through (13,7), then de=0, hsync=vsync=0, px_req=0, pos held (0,0).
- Async reset asserted at pos (5,2) → outputs reset values immediately, before next clk edge.

Source files
------------

// File: rtl/lcd_timing_gen.sv
// Panel timing (hsync/vsync/de), pixel coordinates and RGB generator in the pixel clock domain.
// Define LCD_TG_PATTERN_EN to build the test-pattern logic and the per-frame mode register.
module lcd_timing_gen #(
    parameter int H_ACTIVE = 1366,
    parameter int H_FP     = 30,
    parameter int H_SYNC   = 114,
    parameter int H_BP     = 30,
    parameter int V_ACTIVE = 768,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 4,
    parameter bit SYNC_POL = 1'b1,
    parameter int BPC      = 6,
    parameter int CW       = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [1:0]         mode,
    input  logic [3*BPC-1:0]   px_in,
    output logic               px_req,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic [3*BPC-1:0]   rgb_out,
    output logic [CW-1:0]      pos_x,
    output logic [CW-1:0]      pos_y,
    output logic               frame_start
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int BW       = H_ACTIVE / 8;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   h_q, h_d;
    logic [CW-1:0]   v_q, v_d;

    logic            hsync_q, hsync_d;
    logic            vsync_q, vsync_d;
    logic            de_q, de_d;
    logic [3*BPC-1:0] rgb_q, rgb_d;
    logic [CW-1:0]   pos_x_q, pos_x_d;
    logic [CW-1:0]   pos_y_q, pos_y_d;
    logic            frame_start_q, frame_start_d;

    logic            running;
    logic            h_last;
    logic            v_last;
    logic            frame_last;
    logic            active;
    logic            hs_on;
    logic            vs_on;
    logic [3*BPC-1:0] pix;

    assign running    = (state_q == S_RUN);
    assign h_last     = (h_q == CW'(H_TOTAL - 1));
    assign v_last     = (v_q == CW'(V_TOTAL - 1));
    assign frame_last = h_last && v_last;
    assign active     = running && (h_q < CW'(H_ACTIVE)) && (v_q < CW'(V_ACTIVE));
    assign hs_on      = (h_q >= CW'(HS_START)) && (h_q < CW'(HS_END));
    assign vs_on      = (v_q >= CW'(VS_START)) && (v_q < CW'(VS_END));

    // A stop request only takes effect on the last cycle of a frame, so frames are never cut short.
    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        case (state_q)
            S_IDLE: begin
                h_d = '0;
                v_d = '0;
                if (en) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (h_last) begin
                    h_d = '0;
                    v_d = v_last ? '0 : v_q + CW'(1);
                end else begin
                    h_d = h_q + CW'(1);
                end
                if (frame_last && !en) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                h_d     = '0;
                v_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            h_q     <= '0;
            v_q     <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
        end
    end

`ifdef LCD_TG_PATTERN_EN
    logic [1:0] mode_q, mode_d;
    logic [2:0] bar;

    // Mode is latched on every entry to pixel (0,0) so a frame never mixes two patterns.
    always_comb begin
        mode_d = mode_q;
        if ((state_q == S_IDLE && en) || (running && frame_last)) begin
            mode_d = mode;
        end

        bar = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (h_q >= CW'(k * BW)) begin
                bar = 3'(k);
            end
        end

        pix = '0;
        case (mode_q)
            2'd0:    pix = {{BPC{~bar[1]}}, {BPC{~bar[2]}}, {BPC{~bar[0]}}};
            2'd1:    pix = {(3*BPC){h_q[5] ^ v_q[5]}};
            2'd2:    pix = {3{h_q[BPC-1:0]}};
            default: pix = px_in;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= 2'd0;
        end else begin
            mode_q <= mode_d;
        end
    end
`else
    logic mode_unused;

    assign mode_unused = ^mode;
    assign pix         = px_in;
`endif

    always_comb begin
        hsync_d       = (running && hs_on) ? SYNC_POL : ~SYNC_POL;
        vsync_d       = (running && vs_on) ? SYNC_POL : ~SYNC_POL;
        de_d          = active;
        rgb_d         = active ? pix : '0;
        pos_x_d       = h_q;
        pos_y_d       = v_q;
        frame_start_d = running && (h_q == '0) && (v_q == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            de_q          <= 1'b0;
            rgb_q         <= '0;
            pos_x_q       <= '0;
            pos_y_q       <= '0;
            frame_start_q <= 1'b0;
        end else begin
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            rgb_q         <= rgb_d;
            pos_x_q       <= pos_x_d;
            pos_y_q       <= pos_y_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign px_req      = active;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign rgb_out     = rgb_q;
    assign pos_x       = pos_x_q;
    assign pos_y       = pos_y_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Directed bench for lcd_timing_gen on a 14x8 panel geometry with 6-bit channels.
`timescale 1ns/1ps
module tb_lcd_timing_gen;

    localparam int BPC   = 6;
    localparam int CW    = 12;
    localparam int PW    = 3 * BPC;
    localparam int HT    = 14;
    localparam int VT    = 8;
    localparam int FRAME = HT * VT;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [1:0]    mode;
    logic [PW-1:0] px_in;
    logic          px_req;
    logic          hsync;
    logic          vsync;
    logic          de;
    logic [PW-1:0] rgb_out;
    logic [CW-1:0] pos_x;
    logic [CW-1:0] pos_y;
    logic          frame_start;

    int            n_checks = 0;
    int            n_errors = 0;
    int            px_cnt   = 0;
    logic [PW-1:0] px_drv;
    logic [PW-1:0] bars [8];

    always #5 clk = ~clk;

    lcd_timing_gen #(
        .H_ACTIVE (8),
        .H_FP     (2),
        .H_SYNC   (3),
        .H_BP     (1),
        .V_ACTIVE (4),
        .V_FP     (1),
        .V_SYNC   (2),
        .V_BP     (1),
        .SYNC_POL (1'b1),
        .BPC      (BPC),
        .CW       (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .mode        (mode),
        .px_in       (px_in),
        .px_req      (px_req),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .rgb_out     (rgb_out),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .frame_start (frame_start)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic new_px();
        px_drv = 18'h12345 ^ 18'(px_cnt * 7);
        px_in  = px_drv;
        px_cnt++;
    endtask

    function automatic logic [PW-1:0] exp_pix(input int fmode, input int h, input logic [PW-1:0] px);
`ifdef LCD_TG_PATTERN_EN
        logic [5:0] g;
        g = 6'(h);
        case (fmode)
            0:       return bars[h];
            2:       return {g, g, g};
            default: return px;
        endcase
`else
        if (fmode < 0 || h < 0) return '0;
        return px;
`endif
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_hsync"}, hsync, 0);
        chk({tag, "_vsync"}, vsync, 0);
        chk({tag, "_de"}, de, 0);
        chk({tag, "_rgb"}, rgb_out, 0);
        chk({tag, "_fs"}, frame_start, 0);
        chk({tag, "_px_req"}, px_req, 0);
        chk({tag, "_pos_x"}, pos_x, 0);
        chk({tag, "_pos_y"}, pos_y, 0);
    endtask

    // Sample i shows pixel i of the frame; px_req at sample i refers to pixel i+1.
    task automatic scan_frame(input int fmode, input logic [1:0] next_mode, input bit stop);
        for (int i = 0; i < FRAME; i++) begin
            int h, v, nh, nv;
            bit a, na;
            h  = i % HT;
            v  = i / HT;
            nh = (i + 1) % HT;
            nv = ((i + 1) / HT) % VT;
            a  = (h < 8) && (v < 4);
            na = (nh < 8) && (nv < 4) && !(stop && i == FRAME - 1);
            chk("de", de, a);
            chk("hsync", hsync, (h >= 10) && (h < 13));
            chk("vsync", vsync, (v >= 5) && (v < 7));
            chk("frame_start", frame_start, i == 0);
            chk("pos_x", pos_x, h);
            chk("pos_y", pos_y, v);
            chk("rgb", rgb_out, a ? exp_pix(fmode, h, px_drv) : '0);
            chk("px_req", px_req, na);
            if (i == 30) mode = next_mode;
            if (stop && i == 17) en = 1'b0;
            new_px();
            step();
        end
    endtask

    initial begin
        bars[0] = 18'h3FFFF;
        bars[1] = 18'h3FFC0;
        bars[2] = 18'h00FFF;
        bars[3] = 18'h00FC0;
        bars[4] = 18'h3F03F;
        bars[5] = 18'h3F000;
        bars[6] = 18'h0003F;
        bars[7] = 18'h00000;

        rst_n = 1'b0;
        en    = 1'b0;
        mode  = 2'd0;
        new_px();
        repeat (3) step();
        chk_reset_vals("rst");

        rst_n = 1'b1;
        repeat (3) step();
        chk("idle_px_req", px_req, 0);
        chk("idle_de", de, 0);

        en = 1'b1;
        step();
        chk("start_px_req", px_req, 1);
        chk("start_de", de, 0);
        chk("start_fs", frame_start, 0);
        step();

        scan_frame(0, 2'd2, 1'b0);
        scan_frame(2, 2'd3, 1'b0);
        scan_frame(3, 2'd0, 1'b1);

        for (int k = 0; k < 4; k++) begin
            chk_reset_vals("stopped");
            step();
        end

        en = 1'b1;
        step();
        step();
        for (int i = 0; i < 33; i++) begin
            new_px();
            step();
        end
        chk("pre_rst_pos_x", pos_x, 5);
        chk("pre_rst_pos_y", pos_y, 2);
        chk("pre_rst_de", de, 1);
        chk("pre_rst_rgb", rgb_out, exp_pix(0, 5, px_drv));

        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async_rst");

        en = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (3) step();
        chk("post_rst_px_req", px_req, 0);
        chk("post_rst_de", de, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
